// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: core start/done side plus memory req/ack side.
// mem_be exists only when MAU_BYTE_ENABLE_EN is defined.
interface mem_access_unit_if #(parameter int ADDR_W = 32);
   logic              start;
   logic              we;
   logic [1:0]        size;
   logic              unsigned_ld;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              busy;
   logic              done;
   logic              misalign;
   logic [31:0]       rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;
`ifdef MAU_BYTE_ENABLE_EN
   logic [3:0]        mem_be;
`endif

   // The access unit: initiator towards memory, responder towards the core.
   modport master (
      input  start, we, size, unsigned_ld, addr, wdata, mem_rdata, mem_ack,
`ifdef MAU_BYTE_ENABLE_EN
      output mem_be,
`endif
      output busy, done, misalign, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );

   // The surrounding core and data memory.
   modport slave (
      output start, we, size, unsigned_ld, addr, wdata, mem_rdata, mem_ack,
`ifdef MAU_BYTE_ENABLE_EN
      input  mem_be,
`endif
      input  busy, done, misalign, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS load/store unit: sub-word extract/extend on loads, read-modify-write on sub-word stores.
// Optional MAU_BYTE_ENABLE_EN replaces the RMW with byte-enabled single writes.
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input logic                clk,
   input logic                rst,
   mem_access_unit_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_FIN  = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
      logic r;
      case (sz)
         SZ_BYTE: r = 1'b0;
         SZ_HALF: r = lane[0];
         default: r = (lane != 2'b00);
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic [15:0] wd);
      logic [31:0] r;
      r = old_w;
      case (sz)
         SZ_BYTE: begin
            case (lane)
               2'd0:    r[7:0]   = wd[7:0];
               2'd1:    r[15:8]  = wd[7:0];
               2'd2:    r[23:16] = wd[7:0];
               2'd3:    r[31:24] = wd[7:0];
               default: r        = old_w;
            endcase
         end
         SZ_HALF: begin
            if (lane[1]) r[31:16] = wd;
            else         r[15:0]  = wd;
         end
         default: r = old_w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         2'd3:    b = w[31:24];
         default: b = 8'h00;
      endcase
      h = lane[1] ? w[31:16] : w[15:0];
      case (sz)
         SZ_BYTE: r = {{24{~uns & b[7]}}, b};
         SZ_HALF: r = {{16{~uns & h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

`ifdef MAU_BYTE_ENABLE_EN
   function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lane);
      logic [3:0] r;
      case (sz)
         SZ_BYTE: r = 4'b0001 << lane;
         SZ_HALF: r = lane[1] ? 4'b1100 : 4'b0011;
         default: r = 4'b1111;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r;
      case (sz)
         SZ_BYTE: r = {4{wd[7:0]}};
         SZ_HALF: r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction
`endif

   state_t             state_q, state_d;
   logic               we_q, we_d;
   logic [1:0]         size_q, size_d;
   logic               uns_q, uns_d;
   logic [1:0]         lane_q, lane_d;
   logic [15:0]        wdata_q, wdata_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               misalign_q, misalign_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
`ifdef MAU_BYTE_ENABLE_EN
   logic [3:0]         be_sel_q, be_sel_d;
   logic [3:0]         mem_be_q, mem_be_d;
`endif

   // Next-state and next-output computation; every output is re-registered from state_d.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      lane_d      = lane_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef MAU_BYTE_ENABLE_EN
      be_sel_d    = be_sel_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               we_d    = bus.we;
               size_d  = bus.size;
               uns_d   = bus.unsigned_ld;
               lane_d  = bus.addr[1:0];
               wdata_d = bus.wdata[15:0];
`ifdef MAU_BYTE_ENABLE_EN
               be_sel_d = byte_en(bus.size, bus.addr[1:0]);
`endif
               if (is_misaligned(bus.size, bus.addr[1:0])) begin
                  state_d = S_ERR;
               end else begin
                  mem_addr_d = {bus.addr[ADDR_W-1:2], 2'b00};
                  if (!bus.we) begin
                     state_d = S_RD;
                  end else if (bus.size[1]) begin
                     state_d     = S_WR;
                     mem_wdata_d = bus.wdata;
                  end else begin
`ifdef MAU_BYTE_ENABLE_EN
                     state_d     = S_WR;
                     mem_wdata_d = replicate(bus.size, bus.wdata);
`else
                     state_d     = S_RD;
`endif
                  end
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            if (bus.mem_ack) begin
               if (we_q) begin
                  state_d     = S_WR;
                  mem_wdata_d = merge_word(bus.mem_rdata, size_q, lane_q, wdata_q);
`ifdef MAU_BYTE_ENABLE_EN
                  be_sel_d    = 4'b1111;
`endif
               end else begin
                  state_d = S_FIN;
                  rdata_d = extend_load(bus.mem_rdata, size_q, lane_q, uns_q);
               end
            end else begin
               state_d = S_RD;
            end
         end
         S_WR: begin
            if (bus.mem_ack) state_d = S_FIN;
            else             state_d = S_WR;
         end
         S_FIN:   state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_FIN) || (state_d == S_ERR);
      misalign_d = (state_d == S_ERR);
      mem_req_d  = (state_d == S_RD) || (state_d == S_WR);
      mem_we_d   = (state_d == S_WR);
`ifdef MAU_BYTE_ENABLE_EN
      mem_be_d   = (state_d == S_WR) ? be_sel_d : 4'b0000;
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         lane_q      <= 2'b00;
         wdata_q     <= 16'h0000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         misalign_q  <= 1'b0;
         rdata_q     <= 32'h0000_0000;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= 32'h0000_0000;
`ifdef MAU_BYTE_ENABLE_EN
         be_sel_q    <= 4'b0000;
         mem_be_q    <= 4'b0000;
`endif
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lane_q      <= lane_d;
         wdata_q     <= wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         misalign_q  <= misalign_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef MAU_BYTE_ENABLE_EN
         be_sel_q    <= be_sel_d;
         mem_be_q    <= mem_be_d;
`endif
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.misalign  = misalign_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
`ifdef MAU_BYTE_ENABLE_EN
   assign bus.mem_be    = mem_be_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and a result scoreboard.
// Works with and without MAU_BYTE_ENABLE_EN.
module tb_mem_access_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_W(32)) bus();

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] rd;
      int          lat;
      logic        mis;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;

   logic [31:0] mem [0:63];
   int          rd_delay = 0;
   int          wr_delay = 0;
   int          phase_cnt = 0;
   int          n_reads = 0;
   int          n_writes = 0;
   int          req_cycles = 0;
   int          stab_err = 0;
   logic [31:0] last_wdata = 32'h0;
   logic [3:0]  last_be = 4'h0;
   logic        in_wait = 1'b0;
   logic [64:0] p_bus = 65'h0;
   logic        pl_we = 1'b0;
   logic [5:0]  pl_idx = 6'd0;
   logic [31:0] pl_data = 32'h0;

   // Memory responder: ack after a per-phase programmable number of wait cycles.
   always_comb begin
      bus.mem_ack   = bus.mem_req && (phase_cnt >= (bus.mem_we ? wr_delay : rd_delay));
      bus.mem_rdata = mem[bus.mem_addr[7:2]];
   end

   always @(posedge clk) begin
      if (pl_we) mem[pl_idx] <= pl_data;
      if (bus.mem_req) req_cycles <= req_cycles + 1;
      if (bus.mem_req && bus.mem_ack) begin
         phase_cnt <= 0;
         if (bus.mem_we) begin
            n_writes   <= n_writes + 1;
            last_wdata <= bus.mem_wdata;
`ifdef MAU_BYTE_ENABLE_EN
            last_be <= bus.mem_be;
            for (int i = 0; i < 4; i++)
               if (bus.mem_be[i]) mem[bus.mem_addr[7:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
`else
            last_be <= 4'b1111;
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
`endif
         end else begin
            n_reads <= n_reads + 1;
         end
      end else if (bus.mem_req) begin
         phase_cnt <= phase_cnt + 1;
      end else begin
         phase_cnt <= 0;
      end
      if (in_wait && bus.mem_req && ({bus.mem_we, bus.mem_addr, bus.mem_wdata} != p_bus))
         stab_err <= stab_err + 1;
      in_wait <= bus.mem_req && !bus.mem_ack;
      p_bus   <= {bus.mem_we, bus.mem_addr, bus.mem_wdata};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] data);
      @(negedge clk);
      pl_we = 1'b1; pl_idx = idx; pl_data = data;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   // Drives one request, scrambles the inputs after acceptance and waits for done.
   task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input logic poke,
                         output int lat, output logic mis, output logic [31:0] rd);
      @(negedge clk);
      bus.start = 1'b1; bus.we = w; bus.size = sz; bus.unsigned_ld = u;
      bus.addr = a; bus.wdata = wd;
      @(negedge clk);
      bus.start = 1'b0; bus.we = ~w; bus.size = ~sz; bus.unsigned_ld = ~u;
      bus.addr = ~a; bus.wdata = ~wd;
      lat = -1; mis = 1'b0; rd = 32'h0;
      for (int c = 1; c <= 40; c++) begin
         if (poke && c == 2) begin
            bus.start = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.addr = 32'h10;
         end
         if (poke && c == 3) bus.start = 1'b0;
         if (bus.done) begin
            lat = c; mis = bus.misalign; rd = bus.rdata;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic expect_op(input string tag, input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd, input logic poke,
                            input logic [31:0] e_rd, input int e_lat, input logic e_mis);
      exp_t e;
      int lat;
      logic mis;
      logic [31:0] rd;
      sb.push_back('{rd: e_rd, lat: e_lat, mis: e_mis});
      run_op(w, sz, u, a, wd, poke, lat, mis, rd);
      e = sb.pop_front();
      chk({tag, "_rdata"}, rd, e.rd);
      chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
      chk({tag, "_mis"}, {31'h0, mis}, {31'h0, e.mis});
   endtask

   int sub_lat;
   int rd_before, wr_before, req_before, done_seen;

   initial begin
`ifdef MAU_BYTE_ENABLE_EN
      sub_lat = 2;
`else
      sub_lat = 3;
`endif
      rst = 1'b1;
      bus.start = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.unsigned_ld = 1'b0;
      bus.addr = 32'h0; bus.wdata = 32'h0;
      preload(6'd0,  32'h0000_0000);
      preload(6'd4,  32'h80FF_1234);
      preload(6'd8,  32'h9ABC_0000);
      preload(6'd12, 32'h0000_0000);
      preload(6'd16, 32'h1122_3344);
      preload(6'd20, 32'h5566_7788);
      @(negedge clk);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      chk("rst_done", {31'h0, bus.done}, 32'h0);
      chk("rst_misalign", {31'h0, bus.misalign}, 32'h0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_req", {31'h0, bus.mem_req}, 32'h0);
      chk("rst_we", {31'h0, bus.mem_we}, 32'h0);
      chk("rst_addr", bus.mem_addr, 32'h0);
      chk("rst_wdata", bus.mem_wdata, 32'h0);
`ifdef MAU_BYTE_ENABLE_EN
      chk("rst_be", {28'h0, bus.mem_be}, 32'h0);
`endif
      rst = 1'b0;

      // loads: sign/zero extension across lanes
      expect_op("lb13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 1'b0);
      expect_op("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0000_0080, 2, 1'b0);
      expect_op("lh22",  1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, 32'hFFFF_9ABC, 2, 1'b0);
      expect_op("lhu22", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, 32'h0000_9ABC, 2, 1'b0);
      expect_op("lb10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_0034, 2, 1'b0);
      expect_op("lw10s3", 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1'b0, 32'h80FF_1234, 2, 1'b0);

      // sub-word stores
      rd_before = n_reads; wr_before = n_writes;
      expect_op("sb41", 1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_00AA, 1'b0, 32'h80FF_1234, sub_lat, 1'b0);
      chk("sb41_mem", mem[16], 32'h1122_AA44);
      chk("sb41_nwr", 32'(n_writes - wr_before), 32'd1);
`ifdef MAU_BYTE_ENABLE_EN
      chk("sb41_nrd", 32'(n_reads - rd_before), 32'd0);
      chk("sb41_wdata", last_wdata, 32'hAAAA_AAAA);
      chk("sb41_be", {28'h0, last_be}, 32'h2);
`else
      chk("sb41_nrd", 32'(n_reads - rd_before), 32'd1);
      chk("sb41_wdata", last_wdata, 32'h1122_AA44);
`endif
      expect_op("sh42", 1'b1, 2'b01, 1'b0, 32'h42, 32'h1234_BEEF, 1'b0, 32'h80FF_1234, sub_lat, 1'b0);
      chk("sh42_mem", mem[16], 32'hBEEF_AA44);

      rd_delay = 2;
      expect_op("lw40d2", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF_AA44, 4, 1'b0);
      rd_delay = 0;

      // word store with 3 wait cycles and a start pulse while busy
      wr_delay = 3;
      rd_before = n_reads; stab_err = 0;
      expect_op("sw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'hDEAD_BEEF, 1'b1, 32'hBEEF_AA44, 5, 1'b0);
      wr_delay = 0;
      repeat (3) @(negedge clk);
      chk("sw30_mem", mem[12], 32'hDEAD_BEEF);
      chk("sw30_stable", 32'(stab_err), 32'd0);
      chk("sw30_poke_ignored", 32'(n_reads - rd_before), 32'd0);
      chk("sw30_idle_after", {31'h0, bus.busy}, 32'h0);

      // misaligned accesses
      req_before = req_cycles;
      expect_op("lw06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0, 32'hBEEF_AA44, 1, 1'b1);
      expect_op("lh05", 1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 1'b0, 32'hBEEF_AA44, 1, 1'b1);
      chk("mis_no_req", 32'(req_cycles - req_before), 32'd0);

      // reset in the write wait of a sub-word store
      wr_delay = 10;
      wr_before = n_writes;
      @(negedge clk);
      bus.start = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.addr = 32'h50; bus.wdata = 32'h77;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 20 && !(bus.mem_req && bus.mem_we); c++) @(negedge clk);
      chk("rstwr_in_wr", {31'h0, bus.mem_we}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstwr_busy", {31'h0, bus.busy}, 32'h0);
      chk("rstwr_done", {31'h0, bus.done}, 32'h0);
      chk("rstwr_rdata", bus.rdata, 32'h0);
      chk("rstwr_req", {31'h0, bus.mem_req}, 32'h0);
      chk("rstwr_we", {31'h0, bus.mem_we}, 32'h0);
      chk("rstwr_addr", bus.mem_addr, 32'h0);
      chk("rstwr_wdata", bus.mem_wdata, 32'h0);
`ifdef MAU_BYTE_ENABLE_EN
      chk("rstwr_be", {28'h0, bus.mem_be}, 32'h0);
`endif
      rst = 1'b0;
      wr_delay = 0;
      done_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      chk("rstwr_no_done", 32'(done_seen), 32'd0);
      chk("rstwr_no_write", 32'(n_writes - wr_before), 32'd0);
      chk("rstwr_mem", mem[20], 32'h5566_7788);
      expect_op("lw10_after_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80FF_1234, 2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit between the MIPS datapath and a word-organised data memory. Loads extract a byte or halfword from the addressed word and sign- or zero-extend it to 32 bits. Stores truncate register data to byte or halfword and merge it into the containing word with a read-modify-write sequence. Word accesses pass straight through. The unit handles the core side with a start/done handshake and the memory side with a req/ack handshake.

## Interface
- `ADDR_W`, default 32: byte-address width. Only `addr[ADDR_W-1:2]` reaches memory.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe. Sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 half, 10 word. 11 is treated as word.
- `unsigned_ld`  in  1  1 = zero-extend (lbu/lhu), 0 = sign-extend (lb/lh).
- `addr`  in  ADDR_W  byte address.
- `wdata`  in  32  store data. Low byte/half used for sub-word stores.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `misalign`  out  1  one-cycle pulse together with `done` on an illegal alignment.
- `rdata`  out  32  extended load result. Valid from `done` and held until the next load completes.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write qualifier.
- `mem_addr`  out  ADDR_W  word-aligned address: `{addr[ADDR_W-1:2],2'b00}`.
- `mem_wdata`  out  32  word to write.
- `mem_rdata`  in  32  read word. Sampled on the ack edge.
- `mem_ack`  in  1  request completed. Sampled on the rising edge.

## Operation
- Byte lanes are little-endian: `addr[1:0]`=0 selects bits 7:0, and 3 selects bits 31:24. A halfword with `addr[1]`=1 selects bits 31:16.
- On start, the unit latches `we`, `size`, `unsigned_ld`, `addr` and `wdata`. Input changes after that edge are ignored.
- States:
  - IDLE: waits for start.
  - RD: `mem_req`=1, `mem_we`=0.
  - WR: `mem_req`=1, `mem_we`=1.
  - FIN: `done`=1.
  - ERR: `done`=1, `misalign`=1.
- Transitions:
  - IDLE & start & misaligned → ERR.
  - IDLE & start & load → RD.
  - IDLE & start & store word → WR.
  - IDLE & start & sub-word store → RD.
  - RD & ack & load → FIN, with `rdata` updated.
  - RD & ack & store → WR, with the merged word registered into `mem_wdata`.
  - WR & ack → FIN.
  - FIN and ERR → IDLE.
- Misaligned means a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0. No memory access occurs and `rdata` is unchanged.
- Merge rule: replace only the selected lane(s) of the read word with `wdata[7:0]` or `wdata[15:0]`. All other bits are preserved.
- Extension: a byte uses bit 7 as sign (or 0 when `unsigned_ld`=1) replicated into bits 31:8. A halfword uses bit 15 replicated into bits 31:16. A word load ignores `unsigned_ld`.
- While the unit is not in RD or WR, `mem_req`=0 and `mem_we`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `misalign`=0, `rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. State goes to IDLE.
- `rst` mid-operation abandons the access. `mem_req` is 0 from the next edge. No `done` is issued.
- Each memory phase holds `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stable until the edge at which `mem_ack`=1. The earliest ack counts in the first cycle of the phase.
- Minimum latency, counting start edge = cycle 0 and `done` high in cycle N:
  - load or word store: N=2.
  - sub-word store (RMW): N=3.
  - misaligned: N=1.
- Each wait cycle with `mem_ack` low adds one cycle per phase.
- `start` during busy or FIN is ignored, with no queueing. The earliest new accept is the IDLE cycle after `done`.
- `mem_ack` outside RD/WR is ignored.

## Configuration
- `MAU_BYTE_ENABLE_EN` defined:
  - Adds output `mem_be` [3:0]: 1111 for word, 0011 or 1100 for half, one-hot for byte.
  - Sub-word stores go IDLE → WR directly, with `wdata` lane replicated across `mem_wdata`. Store latency is 2.
  - `mem_be` is 0 outside WR and on reset.
- `MAU_BYTE_ENABLE_EN` undefined: there is no `mem_be` port, and sub-word stores use the RD → WR read-modify-write.

## Test plan
- lb at addr 0x13, memory word 0x80FF_1234, ack on the first cycle → `done` at cycle 2, `rdata`=0xFFFF_FF80. lbu at the same address → 0x0000_0080.
- lh at addr 0x22, word 0x9ABC_0000 → `rdata`=0xFFFF_9ABC. lhu at the same address → 0x0000_9ABC.
- sb with `wdata`=0x0000_00AA at addr 0x41, word 0x1122_3344 → one read, then a write of 0x1122_AA44, `done` at cycle 3. With the macro defined: a single write of 0xAAAA_AAAA with `mem_be`=0010, `done` at cycle 2.
- sw with `mem_ack` held low for 3 cycles per phase → `mem_req` and `mem_addr` stable throughout, `done` at cycle 5. A start pulsed while busy is ignored.
- lw at 0x06 and lh at 0x05 → `done`+`misalign` at cycle 1, `mem_req` never asserted, `rdata` unchanged.
- `rst` asserted in the WR wait of an RMW store → all outputs 0 at the next edge, no `done`. A new lw immediately after completes normally.
